// File: rtl/pim_arb_pkg.sv
// Shared types and constants for the core/PIM buffer arbiter.
package pim_arb_pkg;

  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned BE_W              = 4;
  localparam int unsigned BEAT_W            = 6;
  localparam int unsigned DEFAULT_MAX_BURST = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE     = 2'd1,
    PIM_LOCK = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_PIM  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } buf_req_t;

endpackage

// File: rtl/pim_arb_rr2.sv
// Two-way round-robin pick between core and PIM, with optional PIM priority
// while a PIM burst holds the lock.
module pim_arb_rr2
  import pim_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_core,
  input  logic i_req_pim,
  input  logic i_pim_prio,
  output logic o_gnt_core_c,
  output logic o_gnt_pim_c
);

  req_id_e last_q, last_d;
  logic    gnt_core, gnt_pim;

  // Lone requester always wins; a tie goes to whoever lost most recently.
  always_comb begin
    gnt_core = 1'b0;
    gnt_pim  = 1'b0;
    last_d   = last_q;
    if (i_req_core && i_req_pim) begin
      if (i_pim_prio || (last_q == REQ_CORE)) gnt_pim  = 1'b1;
      else                                    gnt_core = 1'b1;
    end else begin
      gnt_core = i_req_core;
      gnt_pim  = i_req_pim;
    end
    if (gnt_core)     last_d = REQ_CORE;
    else if (gnt_pim) last_d = REQ_PIM;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) last_q <= REQ_PIM;
    else          last_q <= last_d;
  end

  assign o_gnt_core_c = gnt_core;
  assign o_gnt_pim_c  = gnt_pim;

endmodule

// File: rtl/pim_buf_arbiter.sv
// Arbitrates a shared buffer between a core port and a burst-capable PIM port;
// grants are same-cycle, read data returns one cycle later.
module pim_buf_arbiter
  import pim_arb_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 15,
  parameter int unsigned MAX_BURST      = DEFAULT_MAX_BURST
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  input  logic [BE_W-1:0]   i_core_be,
  output logic              o_core_gnt,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_core_rdata,
  input  logic              i_pim_req,
  input  logic              i_pim_we,
  input  logic [ADDR_W-1:0] i_pim_addr,
  input  logic [DATA_W-1:0] i_pim_wdata,
  input  logic [BE_W-1:0]   i_pim_be,
  input  logic              i_pim_last,
  output logic              o_pim_gnt,
  output logic              o_pim_rvalid,
  output logic [DATA_W-1:0] o_pim_rdata,
  output logic [ADDR_W-1:0] o_buf_addr,
  output logic [DATA_W-1:0] o_buf_wr_data,
  output logic [BE_W-1:0]   o_buf_size,
  output logic              o_buf_write,
  output logic              o_buf_read,
  input  logic [DATA_W-1:0] i_buf_rd_data
);

  arb_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
  logic              core_rvalid_q, core_rvalid_d;
  logic              pim_rvalid_q, pim_rvalid_d;
  logic              core_req, pim_req, gnt_core, gnt_pim;
  buf_req_t          core_s, pim_s, sel_s;
  logic              unused_ok;

  // Requests are masked during reset so nothing reaches the buffer.
  assign core_req = i_core_req & i_rst_n;
  assign pim_req  = i_pim_req & i_rst_n;

  pim_arb_rr2 u_rr2 (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_core   (core_req),
    .i_req_pim    (pim_req),
    .i_pim_prio   (state_q == PIM_LOCK),
    .o_gnt_core_c (gnt_core),
    .o_gnt_pim_c  (gnt_pim)
  );

  assign core_s = '{we: i_core_we, addr: i_core_addr, wdata: i_core_wdata, be: i_core_be};
  assign pim_s  = '{we: i_pim_we, addr: i_pim_addr, wdata: i_pim_wdata, be: i_pim_be};

  // Buffer command mux; idle cycles present an all-zero command.
  always_comb begin
    sel_s       = '0;
    o_buf_write = 1'b0;
    o_buf_read  = 1'b0;
    if (gnt_core)     sel_s = core_s;
    else if (gnt_pim) sel_s = pim_s;
    if (gnt_core || gnt_pim) begin
      o_buf_write = sel_s.we;
      o_buf_read  = ~sel_s.we;
    end
  end

  assign o_buf_addr    = {sel_s.addr[ADDR_W-1:2], 2'b00};
  assign o_buf_wr_data = sel_s.wdata;
  assign o_buf_size    = sel_s.be;

  // Buffer decodes the word address itself; byte offset is dropped here.
  assign unused_ok = ^{sel_s.addr[1:0]} ^ (MEM_ADDR_WIDTH == 0);

  // Next-state: PIM bursts hold the lock until last beat or the beat cap.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    beat_inc      = (state_q == PIM_LOCK) ? (beat_q + BEAT_W'(1)) : BEAT_W'(1);
    core_rvalid_d = gnt_core & ~i_core_we;
    pim_rvalid_d  = gnt_pim & ~i_pim_we;
    if (gnt_core) begin
      if (state_q != PIM_LOCK) state_d = CORE;
    end else if (gnt_pim) begin
      if (i_pim_last || (beat_inc >= BEAT_W'(MAX_BURST))) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        state_d = PIM_LOCK;
        beat_d  = beat_inc;
      end
    end else if (state_q != PIM_LOCK) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      core_rvalid_q <= 1'b0;
      pim_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      core_rvalid_q <= core_rvalid_d;
      pim_rvalid_q  <= pim_rvalid_d;
    end
  end

  assign o_core_gnt    = gnt_core;
  assign o_pim_gnt     = gnt_pim;
  assign o_core_rvalid = core_rvalid_q;
  assign o_pim_rvalid  = pim_rvalid_q;
  assign o_core_rdata  = core_rvalid_q ? i_buf_rd_data : '0;
  assign o_pim_rdata   = pim_rvalid_q ? i_buf_rd_data : '0;

endmodule

// File: tb/tb_pim_buf_arbiter.sv
// Self-checking bench for pim_buf_arbiter: vector table plus burst/reset sequences,
// with a scoreboard queue for one-cycle read returns.
module tb_pim_buf_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_core_req = 1'b0, i_core_we = 1'b0;
  logic [31:0] i_core_addr = '0, i_core_wdata = '0;
  logic [3:0]  i_core_be = '0;
  logic        i_pim_req = 1'b0, i_pim_we = 1'b0, i_pim_last = 1'b0;
  logic [31:0] i_pim_addr = '0, i_pim_wdata = '0;
  logic [3:0]  i_pim_be = '0;
  logic [31:0] i_buf_rd_data = '0;
  logic        o_core_gnt, o_core_rvalid, o_pim_gnt, o_pim_rvalid;
  logic [31:0] o_core_rdata, o_pim_rdata, o_buf_addr, o_buf_wr_data;
  logic [3:0]  o_buf_size;
  logic        o_buf_write, o_buf_read;

  pim_buf_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_core_req(i_core_req), .i_core_we(i_core_we), .i_core_addr(i_core_addr),
    .i_core_wdata(i_core_wdata), .i_core_be(i_core_be),
    .o_core_gnt(o_core_gnt), .o_core_rvalid(o_core_rvalid), .o_core_rdata(o_core_rdata),
    .i_pim_req(i_pim_req), .i_pim_we(i_pim_we), .i_pim_addr(i_pim_addr),
    .i_pim_wdata(i_pim_wdata), .i_pim_be(i_pim_be), .i_pim_last(i_pim_last),
    .o_pim_gnt(o_pim_gnt), .o_pim_rvalid(o_pim_rvalid), .o_pim_rdata(o_pim_rdata),
    .o_buf_addr(o_buf_addr), .o_buf_wr_data(o_buf_wr_data), .o_buf_size(o_buf_size),
    .o_buf_write(o_buf_write), .o_buf_read(o_buf_read), .i_buf_rd_data(i_buf_rd_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic rst_n, core_req, core_we, pim_req, pim_we, pim_last, exp_core, exp_pim;
  } vec_t;

  typedef struct {
    logic        pim;
    logic [31:0] data;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] rd_next = 32'h1234_5678;

  function automatic vec_t mk(input logic r, cr, cw, pr, pw, pl, ec, ep);
    mk = '{rst_n: r, core_req: cr, core_we: cw, pim_req: pr, pim_we: pw,
           pim_last: pl, exp_core: ec, exp_pim: ep};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  // One clock cycle: drive at negedge, check combinational and returned outputs 1ns later.
  task automatic do_cycle(input vec_t v, input logic [31:0] ca, input logic [31:0] cd,
                          input logic [3:0] cb, input logic [31:0] pa, input logic [31:0] pd,
                          input logic [3:0] pb, input string tag);
    sb_t         e;
    logic        ecrv, eprv, ew, er;
    logic [31:0] ecrd, eprd, ea, ed;
    logic [3:0]  eb;
    @(negedge i_clk);
    i_rst_n = v.rst_n;
    i_core_req = v.core_req; i_core_we = v.core_we;
    i_core_addr = ca; i_core_wdata = cd; i_core_be = cb;
    i_pim_req = v.pim_req; i_pim_we = v.pim_we; i_pim_last = v.pim_last;
    i_pim_addr = pa; i_pim_wdata = pd; i_pim_be = pb;
    i_buf_rd_data = rd_next;
    rd_next = $urandom;
    #1;
    ecrv = 1'b0; eprv = 1'b0; ecrd = '0; eprd = '0;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.pim) begin eprv = 1'b1; eprd = e.data; end
      else       begin ecrv = 1'b1; ecrd = e.data; end
    end
    chk({tag, " core_rvalid"}, 32'(o_core_rvalid), 32'(ecrv));
    chk({tag, " core_rdata"}, o_core_rdata, ecrd);
    chk({tag, " pim_rvalid"}, 32'(o_pim_rvalid), 32'(eprv));
    chk({tag, " pim_rdata"}, o_pim_rdata, eprd);
    chk({tag, " core_gnt"}, 32'(o_core_gnt), 32'(v.exp_core));
    chk({tag, " pim_gnt"}, 32'(o_pim_gnt), 32'(v.exp_pim));
    ew = 1'b0; er = 1'b0; eb = '0; ea = '0; ed = '0;
    if (v.exp_core) begin
      ew = v.core_we; er = !v.core_we; eb = cb; ea = ca & 32'hFFFF_FFFC; ed = cd;
    end else if (v.exp_pim) begin
      ew = v.pim_we; er = !v.pim_we; eb = pb; ea = pa & 32'hFFFF_FFFC; ed = pd;
    end
    chk({tag, " buf_write"}, 32'(o_buf_write), 32'(ew));
    chk({tag, " buf_read"}, 32'(o_buf_read), 32'(er));
    chk({tag, " buf_size"}, 32'(o_buf_size), 32'(eb));
    if (v.exp_core || v.exp_pim) begin
      chk({tag, " buf_addr"}, o_buf_addr, ea);
      chk({tag, " buf_wr_data"}, o_buf_wr_data, ed);
      if (er) sb_q.push_back('{pim: v.exp_pim, data: rd_next});
    end
  endtask

  task automatic rnd_cycle(input vec_t v, input string tag);
    do_cycle(v, $urandom, $urandom, 4'($urandom), $urandom, $urandom, 4'($urandom), tag);
  endtask

  initial begin
    // fields: rst_n core_req core_we pim_req pim_we pim_last exp_core exp_pim
    tbl.push_back(mk(0,1,0,1,0,1, 0,0));  // reset masks grants
    tbl.push_back(mk(0,1,0,1,0,1, 0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0));  // lone core read
    tbl.push_back(mk(1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,1,1,1, 0,1));  // lone pim write
    tbl.push_back(mk(1,1,0,1,0,1, 1,0));  // alternation
    tbl.push_back(mk(1,1,0,1,0,1, 0,1));
    tbl.push_back(mk(1,1,1,1,0,1, 1,0));
    tbl.push_back(mk(1,1,0,1,1,1, 0,1));
    tbl.push_back(mk(1,1,1,0,0,0, 1,0));
    tbl.push_back(mk(1,1,0,1,0,0, 0,1));  // 4-beat burst vs core
    tbl.push_back(mk(1,1,0,1,0,0, 0,1));
    tbl.push_back(mk(1,1,0,1,0,0, 0,1));
    tbl.push_back(mk(1,1,0,1,0,1, 0,1));
    tbl.push_back(mk(1,1,0,1,0,0, 1,0));  // core gets 5th cycle
    tbl.push_back(mk(1,1,0,1,0,0, 0,1));  // lock, then PIM pause
    tbl.push_back(mk(1,1,0,0,0,0, 1,0));
    tbl.push_back(mk(1,1,0,1,0,0, 0,1));
    tbl.push_back(mk(1,1,0,1,0,0, 0,1));  // lock priority over rr
    tbl.push_back(mk(1,1,0,1,0,1, 0,1));
    tbl.push_back(mk(1,1,0,1,0,0, 1,0));
    tbl.push_back(mk(1,0,0,1,0,0, 0,1));  // read burst, reset on 3rd beat
    tbl.push_back(mk(1,1,0,1,0,0, 0,1));
    tbl.push_back(mk(0,1,0,1,0,0, 0,0));
    tbl.push_back(mk(1,1,0,1,0,0, 1,0));
    tbl.push_back(mk(1,1,0,1,0,0, 0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0));

    foreach (tbl[i]) rnd_cycle(tbl[i], $sformatf("v%0d", i));

    // Core read at unaligned address returns data next cycle.
    rnd_cycle(mk(0,0,0,0,0,0, 0,0), "rd_rst");
    do_cycle(mk(1,1,0,0,0,0, 1,0), 32'h0000_0106, 32'h0, 4'hF,
             32'h0, 32'h0, 4'h0, "rd106");
    rnd_cycle(mk(1,0,0,0,0,0, 0,0), "rd106_ret");

    // Partial core write while PIM is idle; no read return follows.
    do_cycle(mk(1,1,1,0,0,0, 1,0), 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011,
             32'h0, 32'h0, 4'h0, "wr_be3");
    rnd_cycle(mk(1,0,0,0,0,0, 0,0), "wr_be3_after");

    // Burst cap: PIM never signals last, core waits 16 beats.
    rnd_cycle(mk(0,0,0,0,0,0, 0,0), "cap_rst");
    rnd_cycle(mk(1,1,0,0,0,0, 1,0), "cap_core0");
    for (int b = 0; b < 16; b++) rnd_cycle(mk(1,1,0,1,0,0, 0,1), $sformatf("cap_beat%0d", b));
    rnd_cycle(mk(1,1,0,1,0,0, 1,0), "cap_core17");
    rnd_cycle(mk(1,1,0,1,0,0, 0,1), "cap_relock0");
    rnd_cycle(mk(1,1,0,1,0,0, 0,1), "cap_relock1");
    rnd_cycle(mk(1,0,0,0,0,0, 0,0), "drain0");
    rnd_cycle(mk(1,0,0,0,0,0, 0,0), "drain1");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
